capture_segment_framer: RTL and testbench
=========================================

CAPTURE_SEGMENT_FRAMER -- requirements
Module: capture_segment_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default rx_pkg::DATA_WIDTH, meaning the width of one parallel sample word.
REQ-002 SHALL have parameter TS_WIDTH, default buffer_pkg::CLOCK_WIDTH+buffer_pkg::SAMPLE_INDEX_WIDTH, meaning the timestamp width; TS_WIDTH <= DATA_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning the output FIFO entries; power of two, >= 4.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 64, meaning the number of consecutive invalid-data cycles that closes a segment; >= 1.
REQ-005 SHALL have ports as follows; one clock; reset is asynchronous and active-low.
- adc_clk  in  1  clock
- adc_reset_n  in  1  async active-low reset
- adc_reset_state  in  1  sync flush of all framing state and FIFO
- in_data  in  DATA_WIDTH  discriminator sample word
- in_valid  in  1  sample word valid (no backpressure)
- in_ts  in  TS_WIDTH  segment timestamp
- in_ts_valid  in  1  segment-start pulse
- out_data  out  DATA_WIDTH  framed word
- out_user  out  1  1 = header word
- out_last  out  1  last word of segment
- out_valid  out  1  AXIS valid
- out_ready  in  1  AXIS ready
- overflow  out  1  sticky: word dropped (FIFO full)
- ts_collision  out  1  sticky: timestamp dropped (pending busy)

Function
REQ-006 SHALL route every word (header and data) through a single hold register (held_word, held_user, held_full) before FIFO write; at most one FIFO write per cycle.
REQ-007 SHALL latch in_ts into a pending register on in_ts_valid when pending is empty.
REQ-008 SHALL, on in_ts_valid while pending is full, drop the new timestamp and set ts_collision.
REQ-009 SHALL insert a header on the first cycle with pending full and in_valid=0: push held word with last=1 (if held_full), load hold with {zero-extended pending ts, user=1}, clear pending, clear timeout counter.
REQ-010 SHALL, on in_valid=1: push held word with last=0 (if held_full), load in_data into hold with user=0, clear the timeout counter; in_valid words arriving while pending is full belong to the previous segment.
REQ-011 SHALL drop in_valid words when no header has ever been held since reset/flush (hold empty and no open segment); no FIFO write.
REQ-012 SHALL increment the timeout counter on each in_valid=0 cycle while held_full; on reaching IDLE_TIMEOUT, push the held word with last=1, clear held_full and the counter.
REQ-013 SHALL give REQ-009 priority over REQ-012 in the same cycle (a single write with last=1).
REQ-014 SHALL, when a write is required and the FIFO is full, discard that word, set overflow, and continue; hold is still updated.
REQ-015 SHALL present the FIFO head as {out_data, out_user, out_last} with out_valid = not empty; pop on out_valid & out_ready; out_* stable while out_valid & ~out_ready.
REQ-016 SHALL allow simultaneous push and pop when full (pop frees the slot first; no overflow).
REQ-017 SHALL have a latency of exactly 1 cycle from the held-word write event to out_valid when the FIFO is empty.
REQ-018 SHALL wrap FIFO pointers modulo FIFO_DEPTH with an extra wrap bit for full/empty.

Reset
REQ-019 SHALL, on adc_reset_n=0 (async), clear the FIFO, hold, pending, counter, overflow and ts_collision; out_valid=0, out_data/out_user/out_last=0.
REQ-020 SHALL, on adc_reset_state=1 (sync), perform the same clear as REQ-019 except the sticky flags, and ignore in_valid/in_ts_valid that cycle.

Verification
REQ-021 SHALL pass the following scenario: ts=0x55 pulse, 2 idle, 3 valid words A,B,C, then 64 idle, out_ready=1 -> outputs hdr(0x55,user=1,last=0), A, B, C(last=1).
REQ-022 SHALL pass the following scenario: header then IDLE_TIMEOUT idle with no data -> a single header word with last=1.
REQ-023 SHALL pass the following scenario: segment 1 continuous data; ts pulse while data still valid for 3 more cycles, then 1 idle -> all 3 words in segment 1, last on the final one; header 2 follows.
REQ-024 SHALL pass the following scenario: out_ready=0, FIFO_DEPTH=16, 20 words written -> 16 stored, overflow=1, first 16 words read back in order.
REQ-025 SHALL pass the following scenario: two ts pulses 1 cycle apart while in_valid=1 -> second dropped, ts_collision=1, one header emitted.
REQ-026 SHALL pass the following scenario: adc_reset_state mid-segment with FIFO non-empty -> out_valid=0 next cycle, no stray last; the next segment frames correctly.

Source files
------------

// File: rtl/capture_segment_framer.sv
// rtl/capture_segment_framer.sv - frames timestamped capture segments into a word FIFO
package rx_pkg;
    localparam int DATA_WIDTH = 32;
endpackage

package buffer_pkg;
    localparam int CLOCK_WIDTH        = 16;
    localparam int SAMPLE_INDEX_WIDTH = 8;
endpackage

module capture_segment_framer #(
    parameter int DATA_WIDTH   = rx_pkg::DATA_WIDTH,
    parameter int TS_WIDTH     = buffer_pkg::CLOCK_WIDTH + buffer_pkg::SAMPLE_INDEX_WIDTH,
    parameter int FIFO_DEPTH   = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                  adc_clk,
    input  logic                  adc_reset_n,
    input  logic                  adc_reset_state,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic [TS_WIDTH-1:0]   in_ts,
    input  logic                  in_ts_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_user,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic                  ts_collision
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);
    localparam int EW = DATA_WIDTH + 2;

    // FIFO storage: {word, user, last}; pointers carry an extra wrap bit
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // Pending timestamp waiting for a gap in the sample stream
    logic                  pend_full_q, pend_full_d;
    logic [TS_WIDTH-1:0]   pend_ts_q, pend_ts_d;

    // Single hold register every word passes through, so the last flag can be
    // decided one word late
    logic [DATA_WIDTH-1:0] held_word_q, held_word_d;
    logic                  held_user_q, held_user_d;
    logic                  held_full_q, held_full_d;

    logic [CW-1:0]         idle_cnt_q, idle_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  ts_coll_q, ts_coll_d;

    logic                  fifo_empty, fifo_full, pop;
    logic                  push, push_last, wr_en;
    logic [EW-1:0]         head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && out_ready;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // Empty FIFO presents zeros so a flushed or reset block shows no stale word
    assign out_valid    = !fifo_empty;
    assign out_data     = fifo_empty ? '0 : head[EW-1:2];
    assign out_user     = fifo_empty ? 1'b0 : head[1];
    assign out_last     = fifo_empty ? 1'b0 : head[0];
    assign overflow     = overflow_q;
    assign ts_collision = ts_coll_q;

    // Framing decisions: header insertion, data hand-over, idle timeout, FIFO push/pop
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pend_full_d = pend_full_q;
        pend_ts_d   = pend_ts_q;
        held_word_d = held_word_q;
        held_user_d = held_user_q;
        held_full_d = held_full_q;
        idle_cnt_d  = idle_cnt_q;
        overflow_d  = overflow_q;
        ts_coll_d   = ts_coll_q;
        push        = 1'b0;
        push_last   = 1'b0;
        wr_en       = 1'b0;

        if (adc_reset_state) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pend_full_d = 1'b0;
            pend_ts_d   = '0;
            held_word_d = '0;
            held_user_d = 1'b0;
            held_full_d = 1'b0;
            idle_cnt_d  = '0;
        end else begin
            if (pend_full_q && !in_valid) begin
                // Gap in the stream: close the old segment and open a new one
                push        = held_full_q;
                push_last   = 1'b1;
                held_word_d = DATA_WIDTH'(pend_ts_q);
                held_user_d = 1'b1;
                held_full_d = 1'b1;
                pend_full_d = 1'b0;
                idle_cnt_d  = '0;
            end else if (in_valid) begin
                // Words with no open segment have nowhere to go and are dropped
                if (held_full_q) begin
                    push        = 1'b1;
                    held_word_d = in_data;
                    held_user_d = 1'b0;
                    idle_cnt_d  = '0;
                end
            end else if (held_full_q) begin
                if (idle_cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
                    push        = 1'b1;
                    push_last   = 1'b1;
                    held_full_d = 1'b0;
                    idle_cnt_d  = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + CW'(1);
                end
            end

            // The collision test uses the pending state seen at the start of the cycle
            if (in_ts_valid) begin
                if (pend_full_q) begin
                    ts_coll_d = 1'b1;
                end else begin
                    pend_full_d = 1'b1;
                    pend_ts_d   = in_ts;
                end
            end

            // A pop in the same cycle frees a slot for the write
            wr_en = push && (!fifo_full || pop);
            if (push && !wr_en) begin
                overflow_d = 1'b1;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pend_full_q <= 1'b0;
            pend_ts_q   <= '0;
            held_word_q <= '0;
            held_user_q <= 1'b0;
            held_full_q <= 1'b0;
            idle_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            ts_coll_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pend_full_q <= pend_full_d;
            pend_ts_q   <= pend_ts_d;
            held_word_q <= held_word_d;
            held_user_q <= held_user_d;
            held_full_q <= held_full_d;
            idle_cnt_q  <= idle_cnt_d;
            overflow_q  <= overflow_d;
            ts_coll_q   <= ts_coll_d;
        end
    end

    // FIFO array write; contents need no reset since the pointers gate visibility
    always_ff @(posedge adc_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {held_word_q, held_user_q, push_last};
        end
    end
endmodule

// File: tb/tb_capture_segment_framer.sv
// tb/tb_capture_segment_framer.sv - randomized scoreboard bench for capture_segment_framer
module tb_capture_segment_framer;
    localparam int DW    = 32;
    localparam int TW    = 24;
    localparam int DEPTH = 16;
    localparam int TO    = 64;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } item_t;

    logic          clk = 1'b0;
    logic          adc_reset_n = 1'b0;
    logic          adc_reset_state = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic [TW-1:0] in_ts = '0;
    logic          in_ts_valid = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_user;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          overflow;
    logic          ts_collision;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit            m_pend = 0;
    logic [TW-1:0] m_pts = '0;
    item_t         m_hold[$];
    int            m_idle = 0;
    item_t         sb[$];
    item_t         staged[$];
    bit            stage_flush = 0;
    bit            m_ovf = 0, nx_ovf = 0;
    bit            m_coll = 0, nx_coll = 0;

    capture_segment_framer #(
        .DATA_WIDTH(DW), .TS_WIDTH(TW), .FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TO)
    ) dut (
        .adc_clk(clk), .adc_reset_n(adc_reset_n), .adc_reset_state(adc_reset_state),
        .in_data(in_data), .in_valid(in_valid), .in_ts(in_ts), .in_ts_valid(in_ts_valid),
        .out_data(out_data), .out_user(out_user), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .ts_collision(ts_collision)
    );

    always #5 clk = ~clk;

    // Expected FIFO write for the coming edge; occupancy counts the item leaving that edge
    function automatic void push_exp(input item_t it, input bit rdy);
        int occ;
        occ = sb.size() - ((sb.size() > 0 && rdy) ? 1 : 0);
        if (occ < DEPTH) staged.push_back(it);
        else nx_ovf = 1;
    endfunction

    // Segment rules: a timestamp opens a segment at the first gap, data extends it,
    // a long silence or the next header closes it
    function automatic void model_step(input bit iv, input logic [DW-1:0] d, input bit tv,
                                       input logic [TW-1:0] t, input bit rs, input bit rdy);
        item_t it;
        bit had_pend;
        if (rs) begin
            stage_flush = 1;
            m_pend = 0;
            m_hold.delete();
            m_idle = 0;
            return;
        end
        had_pend = m_pend;
        if (m_pend && !iv) begin
            if (m_hold.size() > 0) begin
                it = m_hold[0]; it.l = 1'b1; push_exp(it, rdy);
            end
            m_hold.delete();
            it.d = DW'(m_pts); it.u = 1'b1; it.l = 1'b0;
            m_hold.push_back(it);
            m_pend = 0;
            m_idle = 0;
        end else if (iv) begin
            if (m_hold.size() > 0) begin
                it = m_hold[0]; it.l = 1'b0; push_exp(it, rdy);
                it.d = d; it.u = 1'b0; it.l = 1'b0;
                m_hold[0] = it;
                m_idle = 0;
            end
        end else if (m_hold.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                it = m_hold[0]; it.l = 1'b1; push_exp(it, rdy);
                m_hold.delete();
                m_idle = 0;
            end
        end
        if (tv) begin
            if (had_pend) nx_coll = 1;
            else begin m_pend = 1; m_pts = t; end
        end
    endfunction

    task automatic cyc(input bit iv, input logic [DW-1:0] d, input bit tv,
                       input logic [TW-1:0] t, input bit rs, input bit rdy);
        @(negedge clk);
        #1;
        in_valid = iv; in_data = d; in_ts_valid = tv; in_ts = t;
        adc_reset_state = rs; out_ready = rdy;
        model_step(iv, d, tv, t, rs, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0, rdy);
    endtask

    task automatic data(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b1, $urandom, 1'b0, '0, 1'b0, rdy);
    endtask

    // Monitor: compares just before each rising edge, then retires what that edge consumes
    initial begin
        forever begin
            @(negedge clk);
            #3;
            total++;
            if (out_valid !== (sb.size() != 0)) begin
                bad++;
                $display("FAIL out_valid: got %b want %b", out_valid, sb.size() != 0);
            end
            if (sb.size() != 0) begin
                total++;
                if (out_valid !== 1'b1 || {out_data, out_user, out_last} !== sb[0]) begin
                    bad++;
                    $display("FAIL head: got data=%h user=%b last=%b want data=%h user=%b last=%b",
                             out_data, out_user, out_last, sb[0].d, sb[0].u, sb[0].l);
                end
            end
            total++;
            if (overflow !== m_ovf || ts_collision !== m_coll) begin
                bad++;
                $display("FAIL sticky: got ovf=%b coll=%b want ovf=%b coll=%b",
                         overflow, ts_collision, m_ovf, m_coll);
            end
            if (!adc_reset_n) begin
                total++;
                if ({out_data, out_user, out_last} !== '0) begin
                    bad++;
                    $display("FAIL reset_out: got %h/%b/%b want 0", out_data, out_user, out_last);
                end
            end
            if (sb.size() != 0 && out_ready) void'(sb.pop_front());
            if (stage_flush) begin sb.delete(); stage_flush = 0; end
            while (staged.size() != 0) sb.push_back(staged.pop_front());
            m_ovf  = nx_ovf;
            m_coll = nx_coll;
        end
    end

    initial begin
        int nph, plen, piv, prdy;
        repeat (3) @(negedge clk);
        #1 adc_reset_n = 1'b1;

        // Header, short gap, three words, then timeout closes on the last word
        cyc(1'b0, '0, 1'b1, 24'h55, 1'b0, 1'b1);
        idle(2, 1'b1);
        cyc(1'b1, 32'hA, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 32'hB, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 32'hC, 1'b0, '0, 1'b0, 1'b1);
        idle(TO + 2, 1'b1);

        // Header alone times out as a one-word segment
        cyc(1'b0, '0, 1'b1, 24'h123456, 1'b0, 1'b1);
        idle(TO + 3, 1'b1);

        // Timestamp arrives mid-stream; trailing words stay with the old segment
        cyc(1'b0, '0, 1'b1, 24'h000111, 1'b0, 1'b1);
        idle(1, 1'b1);
        data(5, 1'b1);
        cyc(1'b1, $urandom, 1'b1, 24'h000222, 1'b0, 1'b1);
        data(2, 1'b1);
        idle(1, 1'b1);
        data(2, 1'b1);
        idle(TO + 2, 1'b1);

        // Second timestamp while the first is still pending is dropped
        cyc(1'b0, '0, 1'b1, 24'h000333, 1'b0, 1'b1);
        idle(1, 1'b1);
        data(2, 1'b1);
        cyc(1'b1, $urandom, 1'b1, 24'h000444, 1'b0, 1'b1);
        data(1, 1'b1);
        cyc(1'b1, $urandom, 1'b1, 24'h000555, 1'b0, 1'b1);
        idle(TO + 2, 1'b1);

        // Stalled sink: header plus 19 words overfill a 16-entry FIFO
        cyc(1'b0, '0, 1'b1, 24'h000666, 1'b0, 1'b0);
        idle(1, 1'b0);
        data(19, 1'b0);
        idle(TO + 1, 1'b0);
        idle(DEPTH + 4, 1'b1);

        // Synchronous flush mid-segment with words queued, then a clean segment
        cyc(1'b0, '0, 1'b1, 24'h000777, 1'b0, 1'b0);
        idle(1, 1'b0);
        data(4, 1'b0);
        cyc(1'b1, $urandom, 1'b1, 24'h000888, 1'b1, 1'b0);
        idle(2, 1'b1);
        cyc(1'b0, '0, 1'b1, 24'h000999, 1'b0, 1'b1);
        idle(1, 1'b1);
        data(3, 1'b1);
        idle(TO + 2, 1'b1);

        // Randomized phases with varying data density and sink throughput
        nph = 40;
        for (int p = 0; p < nph; p++) begin
            plen = $urandom_range(150, 50);
            case ($urandom_range(3, 0))
                0: piv = 0;
                1: piv = 20;
                2: piv = 60;
                default: piv = 95;
            endcase
            case ($urandom_range(2, 0))
                0: prdy = 30;
                1: prdy = 80;
                default: prdy = 100;
            endcase
            for (int i = 0; i < plen; i++) begin
                cyc($urandom_range(99, 0) < piv, $urandom, $urandom_range(99, 0) < 4,
                    TW'($urandom), $urandom_range(399, 0) == 0, $urandom_range(99, 0) < prdy);
            end
        end
        idle(TO + DEPTH + 4, 1'b1);

        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
